intr_arbiter: RTL and testbench

- Round-robin arbiter that shares one interrupt handler FSM among NREQ interrupt requesters.
- Selects one pending request and drives the handler's `eql` request line for that winner.
- Holds the grant until the handler acknowledges, the requester withdraws, or a watchdog expires.
- Sits directly in front of the handler; the handler's `ackout` feeds this block's `ack` input.

---
 rtl/intr_arbiter.sv | 137 +++++++++++++
 tb/tb_intr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_arbiter.sv
// Round-robin arbiter sharing one interrupt handler among four requesters.
// Define INTR_ARB_PRIO_EN to make req[0] a fixed high-priority source.
module intr_arbiter #(
   parameter int NREQ     = 4,
   parameter int HOLD_MAX = 15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            ack,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      grant_id,
   output logic            eql,
   output logic            busy,
   output logic            timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_C = 8'(HOLD_MAX);

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [1:0]      grant_id_q, grant_id_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
   logic [1:0]      win;
   logic            rel;

   // Scan p+1, p+2, ... (mod 4) and return the first requester found.
   function automatic logic [1:0] rr_pick(
      input logic [3:0] r,
      input logic [1:0] p
   );
      logic [7:0] dbl;
      logic [3:0] rot;
      logic [2:0] base;
      logic [1:0] off;
      dbl  = {r, r};
      base = {1'b0, p} + 3'd1;
      rot  = dbl[base +: 4];
      off  = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (rot[k]) off = 2'(k);
      end
      return p + 2'd1 + off;
   endfunction

   always_comb begin
      win = rr_pick(req, ptr_q);
`ifdef INTR_ARB_PRIO_EN
      if (req[0]) win = 2'd0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      rel        = 1'b0;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (|req) begin
               state_d    = S_GRANT;
               grant_d    = NREQ'(1) << win;
               grant_id_d = win;
               cnt_d      = 8'd0;
            end
         end
         S_GRANT: begin
            if (ack) begin
               rel = 1'b1;
            end else if (!req[grant_id_q]) begin
               rel = 1'b1;
            end else if (cnt_q == HOLD_C) begin
               rel       = 1'b1;
               timeout_d = 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
            if (rel) begin
               state_d = S_RELEASE;
               grant_d = '0;
`ifdef INTR_ARB_PRIO_EN
               // Serving the priority source leaves the rotation untouched.
               if (grant_id_q != 2'd0) ptr_d = grant_id_q;
`else
               ptr_d = grant_id_q;
`endif
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         grant_id_q <= 2'd0;
         ptr_q      <= 2'd3;
         cnt_q      <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = grant_id_q;
   assign eql      = |grant_q;
   assign busy     = (state_q == S_GRANT) || (state_q == S_RELEASE);
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed plan scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_intr_arbiter;

   localparam int HOLD = 15;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic       ack;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       eql;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   intr_arbiter #(.NREQ(4), .HOLD_MAX(HOLD)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .ack      (ack),
      .grant    (grant),
      .grant_id (grant_id),
      .eql      (eql),
      .busy     (busy),
      .timeout  (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 = idle, 1 = serving owner, 2 = guard cycle.
   typedef struct {
      int phase;
      int owner;
      int last;
      int waited;
      int ptr;
      bit tmo;
   } model_t;

   model_t m;

   function automatic int pick(input logic [3:0] r, input int p);
`ifdef INTR_ARB_PRIO_EN
      if (r[0]) return 0;
`endif
      for (int k = 1; k <= 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic model_t model_reset();
      model_t n;
      n.phase = 0; n.owner = 0; n.last = 0;
      n.waited = 0; n.ptr = 3; n.tmo = 0;
      return n;
   endfunction

   function automatic model_t model_next(input model_t c,
                                         input logic [3:0] r,
                                         input logic a);
      model_t n;
      bit done;
      n = c;
      n.tmo = 0;
      done = 0;
      if (c.phase == 0) begin
         if (r != 0) begin
            n.phase = 1;
            n.owner = pick(r, c.ptr);
            n.last = n.owner;
            n.waited = 0;
         end
      end else if (c.phase == 1) begin
         if (a || !r[c.owner]) begin
            done = 1;
         end else if (c.waited >= HOLD) begin
            done = 1;
            n.tmo = 1;
         end else begin
            n.waited = (c.waited < 255) ? c.waited + 1 : 255;
         end
         if (done) begin
            n.phase = 2;
`ifdef INTR_ARB_PRIO_EN
            if (c.owner != 0) n.ptr = c.owner;
`else
            n.ptr = c.owner;
`endif
         end
      end else begin
         n.phase = 0;
      end
      return n;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) m <= model_reset();
      else        m <= model_next(m, req, ack);
   end

   always @(negedge clock) begin
      int eg;
      eg = (m.phase == 1) ? (1 << m.owner) : 0;
      chk("grant", int'(grant), eg);
      chk("grant_id", int'(grant_id), m.last);
      chk("eql", int'(eql), int'(m.phase == 1));
      chk("busy", int'(busy), int'(m.phase != 0));
      chk("timeout", int'(timeout), int'(m.tmo));
      chk("onehot", int'($countones(grant) <= 1), 1);
      chk("eql_vs_grant", int'(eql), int'(grant != 0));
      chk("tmo_eql_excl", int'(timeout && eql), 0);
   end

   task automatic step(input logic [3:0] r, input logic a);
      req = r;
      ack = a;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req = 4'b0;
      ack = 1'b0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   int n_eql, n_to, n;
   logic [3:0] seq [6];
   int ids [6];
   int drop [4];

   initial begin
      reset = 1'b1;
      req   = 4'b0;
      ack   = 1'b0;
      #2 reset = 1'b0;
      #3;
      chk("rst_grant", int'(grant), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_timeout", int'(timeout), 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Single request, ack in the fourth grant cycle.
      step(4'b0100, 1'b0);
      chk("t1_grant", int'(grant), 4);
      chk("t1_id", int'(grant_id), 2);
      repeat (3) step(4'b0100, 1'b0);
      chk("t1_eql4", int'(eql), 1);
      step(4'b0100, 1'b1);
      chk("t1_rel_grant", int'(grant), 0);
      chk("t1_rel_busy", int'(busy), 1);
      step(4'b0000, 1'b0);
      chk("t1_idle_busy", int'(busy), 0);
      chk("t1_idle_id", int'(grant_id), 2);

`ifndef INTR_ARB_PRIO_EN
      // All four requesting, prompt acks: strict rotation from 0.
      do_reset();
      n = 0;
      for (int i = 0; i < 6; i++) seq[i] = 4'b0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         step(4'b1111, 1'b1);
         if (grant != 0) begin
            seq[n] = grant;
            n++;
         end
      end
      chk("t2_g0", int'(seq[0]), 1);
      chk("t2_g1", int'(seq[1]), 2);
      chk("t2_g2", int'(seq[2]), 4);
      chk("t2_g3", int'(seq[3]), 8);
      chk("t2_g4", int'(seq[4]), 1);
`else
      // Priority source 0 with requesters dropping briefly after service.
      do_reset();
      n = 0;
      for (int i = 0; i < 6; i++) ids[i] = -1;
      for (int i = 0; i < 4; i++) drop[i] = 0;
      for (int i = 0; i < 80 && n < 6; i++) begin
         logic [3:0] r;
         logic a;
         int gid;
         r = 4'b1011;
         for (int b = 0; b < 4; b++) if (drop[b] > 0) r[b] = 1'b0;
         a = (grant != 0);
         gid = int'(grant_id);
         if (a) begin
            ids[n] = gid;
            n++;
         end
         step(r, a);
         for (int b = 0; b < 4; b++) if (drop[b] > 0) drop[b]--;
         if (a) drop[gid] = 2;
      end
      chk("t6_o0", ids[0], 0);
      chk("t6_o1", ids[1], 1);
      chk("t6_o2", ids[2], 0);
      chk("t6_o3", ids[3], 3);
      chk("t6_o4", ids[4], 0);
      chk("t6_o5", ids[5], 1);
`endif

      // Watchdog release, then fairness skips the timed-out requester.
      do_reset();
      step(4'b1010, 1'b0);
      chk("t3_grant", int'(grant), 2);
      n_eql = 1;
      n_to = 0;
      for (int i = 0; i < 40; i++) begin
         step(4'b1010, 1'b0);
         if (eql) n_eql++;
         if (timeout) n_to++;
         if (!busy) break;
      end
      chk("t3_eql_cycles", n_eql, 16);
      chk("t3_timeout_cycles", n_to, 1);
      step(4'b1010, 1'b0);
      chk("t3_next_id", int'(grant_id), 3);

      // Withdraw after two grant cycles.
      do_reset();
      step(4'b1000, 1'b0);
      chk("t4_id", int'(grant_id), 3);
      step(4'b1000, 1'b0);
      step(4'b0000, 1'b0);
      chk("t4_rel_grant", int'(grant), 0);
      chk("t4_rel_busy", int'(busy), 1);
      chk("t4_rel_tmo", int'(timeout), 0);
      step(4'b0000, 1'b0);
      chk("t4_keep_id", int'(grant_id), 3);
      chk("t4_idle_tmo", int'(timeout), 0);

      // Asynchronous reset in the middle of a grant.
      do_reset();
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      #1 reset = 1'b0;
      #1;
      chk("t5_grant", int'(grant), 0);
      chk("t5_eql", int'(eql), 0);
      chk("t5_busy", int'(busy), 0);
      @(negedge clock);
      reset = 1'b1;
      step(4'b0001, 1'b0);
      chk("t5_first", int'(grant), 1);
      step(4'b0001, 1'b1);
      step(4'b0000, 1'b0);

      // Random traffic; every third segment never acknowledges.
      do_reset();
      begin
         logic [3:0] r;
         r = 4'b0;
         for (int seg = 0; seg < 30; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 0 : 30;
            for (int c = 0; c < 100; c++) begin
               for (int b = 0; b < 4; b++) begin
                  if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
               end
               step(r, 1'($urandom_range(0, 99) < pct));
            end
         end
      end

      @(negedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
